// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the UART TX arbiter and the
// transmitter.
//   req/req_data       producers -> arbiter   pending flags and their bytes
//   gnt                arbiter -> producers   one-cycle byte-captured pulse
//   grant_id/tx_data   arbiter -> transmitter winner index and captured byte
//   tx_load            arbiter -> transmitter one-cycle load strobe
//   tx_busy/tx_done    transmitter -> arbiter frame in progress / frame end
//   active             arbiter status, high while not IDLE
//   err                arbiter timeout pulse (only with UART_ARB_TIMEOUT_EN)
// The master modport is the arbiter side; the slave modport is the
// producer/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic [ID_W-1:0]         grant_id;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_load;
  logic                    tx_busy;
  logic                    tx_done;
  logic                    active;
`ifdef UART_ARB_TIMEOUT_EN
  logic                    err;
`endif

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output gnt, grant_id, tx_data, tx_load, active
`ifdef UART_ARB_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  gnt, grant_id, tx_data, tx_load, active
`ifdef UART_ARB_TIMEOUT_EN
    , input err
`endif
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmit channel among
// N_REQ byte sources. Captures the winner's byte, pulses tx_load/gnt for one
// cycle, then follows the transmitter busy/done handshake to frame end.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  uart_tx_arbiter_if.master (req, req_data, gnt, grant_id, tx_data,
//        tx_load, tx_busy, tx_done, active, err)
// Optional build macro UART_ARB_TIMEOUT_EN: adds a TIMEOUT-cycle watchdog on
// WAIT_BUSY/WAIT_DONE that aborts to IDLE and pulses err.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 4095
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  // Elaboration-time guard against illegal configurations.
  if (N_REQ < 2 || N_REQ > 16 || (1 << ID_W) < N_REQ || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  state_t              state;
  logic [ID_W-1:0]     last;
  logic [N_REQ-1:0]    gnt_q;
  logic [ID_W-1:0]     grant_id_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_load_q;
  logic                active_q;

  logic [2*N_REQ-1:0]  req_dbl;
  logic [N_REQ-1:0]    req_rot;
  int                  first_j;
  int                  win_sum;
  logic [ID_W-1:0]     win_idx;
  logic [N_REQ-1:0]    win_onehot;
  logic [DATA_W-1:0]   win_byte;

  // Winner search: rotate req so bit 0 is requester last+1, take the lowest
  // set bit, then map back to an absolute index.
  always_comb begin
    req_dbl = {bus.req, bus.req};
    req_rot = N_REQ'(req_dbl >> (int'(last) + 1));
    first_j = 0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) first_j = j;
    end
    win_sum = int'(last) + 1 + first_j;
    if (win_sum >= N_REQ) win_sum = win_sum - N_REQ;
    win_idx    = ID_W'(win_sum);
    win_onehot = '0;
    win_byte   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_sum == i) begin
        win_onehot[i] = 1'b1;
        win_byte      = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
  logic             tmo_hit;

  // Last waiting cycle: the counter advances on this edge to TIMEOUT.
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign bus.err = err_q;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= ID_W'(N_REQ - 1);
      gnt_q      <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_load_q  <= 1'b0;
      active_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      gnt_q     <= '0;
      tx_load_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // A busy transmitter in IDLE belongs to someone else; hold off.
          if (|bus.req && !bus.tx_busy) begin
            tx_data_q  <= win_byte;
            grant_id_q <= win_idx;
            gnt_q      <= win_onehot;
            tx_load_q  <= 1'b1;
            last       <= win_idx;
            active_q   <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT_BUSY: begin
          // tx_done first: a frame may finish before busy was ever seen.
          if (bus.tx_done) begin
            state    <= IDLE;
            active_q <= 1'b0;
          end else if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            state    <= IDLE;
            active_q <= 1'b0;
            err_q    <= 1'b1;
          end
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            state    <= IDLE;
            active_q <= 1'b0;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            state    <= IDLE;
            active_q <= 1'b0;
            err_q    <= 1'b1;
          end
          tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
        default: begin
          state    <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.grant_id = grant_id_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_load  = tx_load_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset values, single frame, round-robin
// order, pointer wrap, busy-in-IDLE hold-off, mid-frame reset and (when built
// with UART_ARB_TIMEOUT_EN) the watchdog abort.
module tb_uart_tx_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_gnt"},      32'(bus.gnt),      32'h0);
    check({tag, "_tx_load"},  32'(bus.tx_load),  32'h0);
    check({tag, "_tx_data"},  32'(bus.tx_data),  32'h0);
    check({tag, "_grant_id"}, 32'(bus.grant_id), 32'h0);
    check({tag, "_active"},   32'(bus.active),   32'h0);
`ifdef UART_ARB_TIMEOUT_EN
    check({tag, "_err"},      32'(bus.err),      32'h0);
`endif
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.req     = '0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    repeat (2) step();
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full frame: grant on the next edge, load pulse ends, transmitter
  // busy for three cycles, then tx_done returns the arbiter to IDLE.
  task automatic frame(input int id, input logic [7:0] byte_exp, input logic [3:0] req_after);
    step();
    check("gnt",      32'(bus.gnt),      32'(1) << id);
    check("tx_load",  32'(bus.tx_load),  32'h1);
    check("grant_id", 32'(bus.grant_id), 32'(id));
    check("tx_data",  32'(bus.tx_data),  32'(byte_exp));
    check("active",   32'(bus.active),   32'h1);
    bus.req = req_after;
    step();
    check("gnt_pulse",  32'(bus.gnt),     32'h0);
    check("load_pulse", 32'(bus.tx_load), 32'h0);
    bus.tx_busy = 1'b1;
    repeat (3) begin
      step();
      check("no_reload",   32'(bus.tx_load), 32'h0);
      check("active_busy", 32'(bus.active),  32'h1);
    end
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("active_done", 32'(bus.active),  32'h0);
    check("data_hold",   32'(bus.tx_data), 32'(byte_exp));
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;

    // Single requester, single frame.
    do_reset();
    bus.req_data = 32'h0000_00A5;
    bus.req      = 4'b0001;
    frame(0, 8'hA5, 4'b0000);

    // All four requesting continuously: strict rotation from requester 0.
    do_reset();
    bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    bus.req      = 4'b1111;
    frame(0, 8'h10, 4'b1111);
    frame(1, 8'h21, 4'b1111);
    frame(2, 8'h32, 4'b1111);
    frame(3, 8'h43, 4'b1111);
    frame(0, 8'h10, 4'b0000);

    // Pointer wrap: after a grant to 2 the scan starts at 3, so 0 beats 2.
    bus.req = 4'b0100;
    frame(2, 8'h32, 4'b0000);
    bus.req = 4'b0101;
    frame(0, 8'h10, 4'b0100);
    frame(2, 8'h32, 4'b0000);

    // Busy transmitter in IDLE blocks arbitration.
    bus.tx_busy = 1'b1;
    bus.req     = 4'b0010;
    repeat (3) begin
      step();
      check("busy_gnt",    32'(bus.gnt),     32'h0);
      check("busy_load",   32'(bus.tx_load), 32'h0);
      check("busy_active", 32'(bus.active),  32'h0);
    end
    bus.tx_busy = 1'b0;
    frame(1, 8'h21, 4'b0000);

    // Reset while waiting for tx_done, then the pointer restarts at 3 -> 0.
    bus.req = 4'b0001;
    step();
    check("pre_rst_grant", 32'(bus.grant_id), 32'h0);
    bus.req = 4'b0000;
    step();
    bus.tx_busy = 1'b1;
    step();
    check("pre_rst_active", 32'(bus.active), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    bus.tx_busy = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 4'b1000;
    frame(3, 8'h43, 4'b0000);

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never responds: abort after TMO waiting cycles.
    bus.req = 4'b0001;
    step();
    check("tmo_grant", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    step();
    repeat (TMO - 1) begin
      step();
      check("tmo_err_early", 32'(bus.err),    32'h0);
      check("tmo_active",    32'(bus.active), 32'h1);
    end
    step();
    check("tmo_err",        32'(bus.err),    32'h1);
    check("tmo_idle",       32'(bus.active), 32'h0);
    step();
    check("tmo_err_pulse",  32'(bus.err),    32'h0);
    bus.req = 4'b0010;
    frame(1, 8'h21, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
